// File: rtl/sr_bank_ctrl.sv
// Round-robin sequencer for a bank of SR flops: one set/clear strobe per granted command,
// followed by a readback check and a one-cycle ack (with err) to the requester that was served.
module sr_bank_ctrl #(
    parameter int NREQ = 4,
    parameter int NFF  = 8,
    parameter int IDXW = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      cmd,
    input  logic [IDXW*NREQ-1:0]   idx,
    output logic [NREQ-1:0]        ack,
    output logic                   err,
    output logic [NFF-1:0]         s_vec,
    output logic [NFF-1:0]         r_vec,
    input  logic [NFF-1:0]         q_vec,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int PW = $clog2(NREQ);
    localparam logic [IDXW:0] NFF_L = (IDXW+1)'(NFF);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CHECK = 2'd2} state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, owner, win;
    logic [IDXW-1:0] idx_q, win_idx;
    logic [1:0]      win_cmd;
    logic [NREQ-1:0] req_rot;
    logic [NFF-1:0]  win_hot;
    logic            bad, expected, win_vld, win_legal, win_set, chk_q;

    function automatic logic [NFF-1:0] decode(input logic [IDXW-1:0] x);
        logic [NFF-1:0] d;
        d = '0;
        for (int i = 0; i < NFF; i++) d[i] = (x == IDXW'(i));
        return d;
    endfunction

    // Handshake: a requester holds req (with stable cmd/idx) until it sees its one-cycle
    // ack; once latched in IDLE its op completes even if req drops meanwhile.
    always_comb begin
        req_rot = NREQ'({req, req} >> ptr);
        win_vld = 1'b0;
        win     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_vld && req_rot[k]) begin
                win_vld = 1'b1;
                win     = PW'((int'(ptr) + k) % NREQ);
            end
        end
        win_cmd = '0;
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                win_cmd = cmd[2*i +: 2];
                win_idx = idx[IDXW*i +: IDXW];
            end
        end
        win_hot   = decode(win_idx);
        win_legal = (win_cmd != 2'b00) && ({1'b0, win_idx} < NFF_L);
        // Toggle looks at the flag as it stands at the grant edge.
        win_set   = (win_cmd == 2'b10) || ((win_cmd == 2'b11) && !(|(q_vec & win_hot)));
    end

    assign chk_q     = |(q_vec & decode(idx_q));
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        ack      = '0;
        err      = 1'b0;
        case (state)
            IDLE:  if (win_vld) state_nx = win_legal ? ISSUE : CHECK;
            ISSUE: state_nx = CHECK;
            CHECK: begin
                state_nx = IDLE;
                for (int i = 0; i < NREQ; i++) ack[i] = (owner == PW'(i));
                err = bad || (chk_q != expected);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            idx_q    <= '0;
            bad      <= 1'b0;
            expected <= 1'b0;
            s_vec    <= '0;
            r_vec    <= '0;
        end else begin
            state <= state_nx;
            s_vec <= '0;
            r_vec <= '0;
            if (state == IDLE && win_vld) begin
                owner    <= win;
                idx_q    <= win_idx;
                bad      <= !win_legal;
                expected <= win_legal && win_set;
                if (win_legal && win_set) s_vec <= win_hot;
                else if (win_legal)       r_vec <= win_hot;
            end
            // The served requester drops to lowest priority for the next grant.
            if (state == CHECK) ptr <= (owner == PW'(NREQ-1)) ? '0 : owner + 1'b1;
        end
    end

endmodule
